// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
// The packet-lock FSM states are only used when STREAM_DEMUX_PKT_LOCK_EN is defined.
package stream_demux_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/stream_demux_reg_slice.sv
// One-entry valid/ready register stage (module stream_reg_slice).
// o_free is combinational: empty, or draining this cycle.
module stream_reg_slice #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_free,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign o_free  = ~r_valid | i_ready;
  assign w_load  = i_valid & o_free;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1to2.sv
// 1-to-2 stream demux with a register stage per output.
// Define STREAM_DEMUX_PKT_LOCK_EN to keep whole packets on one output.
module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic             in_last,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic             out0_last,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             out1_last
);

  logic             w_sel;
  logic             w_free0;
  logic             w_free1;
  logic             w_acc;
  logic [WIDTH:0]   w_pl0;
  logic [WIDTH:0]   w_pl1;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
  state_t r_state;
  logic   r_locked_sel;

  assign w_sel = (r_state == LOCKED) ? r_locked_sel : in_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_locked_sel <= 1'b0;
    end else if (w_acc) begin
      unique case (r_state)
        IDLE: begin
          if (!in_last) begin
            r_state      <= LOCKED;
            r_locked_sel <= in_sel;
          end
        end
        LOCKED: begin
          if (in_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  assign w_sel = in_sel;
`endif

  // Ready follows only the target stage, never in_valid.
  assign in_ready = ~rst & (w_sel ? w_free1 : w_free0);
  assign w_acc    = in_valid & in_ready;

  stream_reg_slice #(.W(WIDTH + 1)) u_slice0 (
    .clk     (clk),
    .rst     (rst),
    .i_data  ({in_last, in_data}),
    .i_valid (w_acc & ~w_sel),
    .o_free  (w_free0),
    .o_data  (w_pl0),
    .o_valid (out0_valid),
    .i_ready (out0_ready)
  );

  stream_reg_slice #(.W(WIDTH + 1)) u_slice1 (
    .clk     (clk),
    .rst     (rst),
    .i_data  ({in_last, in_data}),
    .i_valid (w_acc & w_sel),
    .o_free  (w_free1),
    .o_data  (w_pl1),
    .o_valid (out1_valid),
    .i_ready (out1_ready)
  );

  assign out0_data = w_pl0[WIDTH-1:0];
  assign out0_last = w_pl0[WIDTH];
  assign out1_data = w_pl1[WIDTH-1:0];
  assign out1_last = w_pl1[WIDTH];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Scoreboard bench for stream_demux_1to2 (directed cases plus random traffic).
// Follows STREAM_DEMUX_PKT_LOCK_EN in the same way as the design.
module tb_stream_demux_1to2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sel = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out1_valid;
  logic       out0_ready = 1'b0, out1_ready = 1'b0;
  logic       out0_last, out1_last;

  int checks = 0;
  int failures = 0;

  // Expected beats per output, {last, data}; at most one can be pending.
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  // Packet-lock view of the model: inside a packet, or not.
  bit m_in_pkt = 1'b0;
  bit m_pkt_sel = 1'b0;

  stream_demux_1to2 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_last  (out0_last),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_last  (out1_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check in_ready, update model at posedge.
  task automatic step(input logic r, input logic v, input logic s,
                      input logic l, input logic [7:0] d,
                      input logic r0, input logic r1);
    bit tgt;
    bit exp_rdy;
    bit acc;
    @(negedge clk);
    rst = r; in_valid = v; in_sel = s; in_last = l; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
`ifdef STREAM_DEMUX_PKT_LOCK_EN
    tgt = m_in_pkt ? m_pkt_sel : s;
`else
    tgt = s;
`endif
    if (r) exp_rdy = 1'b0;
    else if (tgt) exp_rdy = (q1.size() == 0) || r1;
    else exp_rdy = (q0.size() == 0) || r0;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    if (r) begin
      q0.delete(); q1.delete();
      m_in_pkt = 1'b0; m_pkt_sel = 1'b0;
    end else if (acc) begin
      if (tgt) q1.push_back({l, d});
      else q0.push_back({l, d});
      if (!m_in_pkt && !l) begin
        m_in_pkt = 1'b1; m_pkt_sel = s;
      end else if (m_in_pkt && l) begin
        m_in_pkt = 1'b0;
      end
    end
  endtask

  // Monitor: output valid must match pending beats; transfer pops.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("out0_valid", {31'b0, out0_valid}, {31'b0, q0.size() != 0});
      if (out0_valid && q0.size() != 0) begin
        chk("out0_data", {24'b0, out0_data}, {24'b0, q0[0][7:0]});
        chk("out0_last", {31'b0, out0_last}, {31'b0, q0[0][8]});
      end
      if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
      chk("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() != 0});
      if (out1_valid && q1.size() != 0) begin
        chk("out1_data", {24'b0, out1_data}, {24'b0, q1[0][7:0]});
        chk("out1_last", {31'b0, out1_last}, {31'b0, q1[0][8]});
      end
      if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
    end
  end

  initial begin
    // Reset: two cycles, then everything must read zero.
    step(1, 1, 0, 1, 8'hFF, 1, 1);
    step(1, 1, 1, 1, 8'hFF, 1, 1);
    #1;
    chk("rst_out0_data", {24'b0, out0_data}, 32'h0);
    chk("rst_out1_data", {24'b0, out1_data}, 32'h0);
    chk("rst_out0_last", {31'b0, out0_last}, 32'h0);
    chk("rst_out1_last", {31'b0, out1_last}, 32'h0);

    // Routing.
    step(0, 1, 0, 1, 8'h11, 1, 1);
    step(0, 1, 1, 1, 8'h22, 1, 1);
    step(0, 0, 0, 1, 8'h00, 1, 1);

    // Backpressure on out0, then release.
    step(0, 1, 0, 1, 8'hA5, 0, 1);
    step(0, 1, 0, 1, 8'h5A, 0, 1);
    step(0, 1, 0, 1, 8'h5A, 0, 1);
    step(0, 1, 0, 1, 8'h5A, 1, 1);
    step(0, 0, 0, 1, 8'h00, 1, 1);
    step(0, 0, 0, 1, 8'h00, 1, 1);

    // Load and drain on out1 in the same cycle.
    step(0, 1, 1, 1, 8'h33, 0, 0);
    step(0, 1, 1, 1, 8'h44, 0, 1);
    step(0, 0, 0, 1, 8'h00, 0, 0);
    step(0, 0, 0, 1, 8'h00, 1, 1);

    // 3-beat packet on sel 1 with sel toggled, then a beat on sel 0.
    step(0, 1, 1, 0, 8'h61, 1, 1);
    step(0, 1, 0, 0, 8'h62, 1, 1);
    step(0, 1, 0, 1, 8'h63, 1, 1);
    step(0, 1, 0, 1, 8'h64, 1, 1);
    step(0, 0, 0, 1, 8'h00, 1, 1);

    // Reset in the middle of a packet with beats buffered.
    step(0, 1, 1, 0, 8'h71, 0, 0);
    step(1, 1, 1, 0, 8'h72, 0, 0);
    step(0, 1, 0, 1, 8'h73, 1, 1);
    step(0, 0, 0, 1, 8'h00, 1, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0),
           ($urandom_range(3) != 0),
           $urandom_range(1),
           ($urandom_range(2) == 0),
           8'($urandom),
           ($urandom_range(9) < 7),
           ($urandom_range(9) < 7));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h00, 1, 1);
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
